// File: rtl/vmul_group_sched_if.sv
// +------------------------------------------------------------------+
// | vmul_group_sched_if                                              |
// | Issue/group/capture bundle for the grouped vector multiply sched.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface vmul_group_sched_if #(
    parameter int NUMLANES = 8,
    parameter int MULLANES = 4,
    parameter int GRPBITS  = 1
);
    logic                en;
    logic                squash;
    logic                issue_valid;
    logic                issue_ready;
    logic [NUMLANES-1:0] issue_mask;
    logic [4:0]          issue_op;
    logic                grp_valid;
    logic [GRPBITS-1:0]  grp_sel;
    logic [MULLANES-1:0] grp_mask;
    logic [4:0]          grp_op;
    logic                cap_valid;
    logic [GRPBITS-1:0]  cap_sel;
    logic                stall;
    logic                done;

    modport master (
        output en, squash, issue_valid, issue_mask, issue_op,
        input  issue_ready, grp_valid, grp_sel, grp_mask, grp_op,
        input  cap_valid, cap_sel, stall, done
    );

    modport slave (
        input  en, squash, issue_valid, issue_mask, issue_op,
        output issue_ready, grp_valid, grp_sel, grp_mask, grp_op,
        output cap_valid, cap_sel, stall, done
    );
endinterface

`default_nettype wire

// File: rtl/vmul_group_sched.sv
// +------------------------------------------------------------------+
// | vmul_group_sched                                                 |
// | Walks a vector multiply in MULLANES-wide groups, skipping empty  |
// | groups, and tags fixed-latency results with their group index.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module vmul_group_sched #(
    parameter int NUMLANES = 8,
    parameter int MULLANES = 4,
    parameter int GRPBITS  = 1,
    parameter int LAT      = 2
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    vmul_group_sched_if.slave  bus
);
    localparam int NUMGRP = NUMLANES / MULLANES;
    localparam int CNTW   = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [GRPBITS-1:0]  r_cur;
    logic [NUMLANES-1:0] r_mask;
    logic [4:0]          r_op;
    logic [CNTW-1:0]     r_cnt;
    logic [LAT-1:0]      r_pv;
    logic [GRPBITS-1:0]  r_ps [LAT];

    logic                w_first_found;
    logic [GRPBITS-1:0]  w_first_grp;
    logic                w_next_found;
    logic [GRPBITS-1:0]  w_next_grp;
    logic [MULLANES-1:0] w_cur_slice;
    logic                w_grp_valid;

    // Scan downward so the lowest qualifying group is the one that sticks.
    always_comb begin
        w_first_found = 1'b0;
        w_first_grp   = '0;
        w_next_found  = 1'b0;
        w_next_grp    = '0;
        w_cur_slice   = '0;
        for (int g = NUMGRP - 1; g >= 0; g--) begin
            if (|bus.issue_mask[g*MULLANES +: MULLANES]) begin
                w_first_found = 1'b1;
                w_first_grp   = GRPBITS'(g);
            end
            if ((g > int'(r_cur)) && (|r_mask[g*MULLANES +: MULLANES])) begin
                w_next_found = 1'b1;
                w_next_grp   = GRPBITS'(g);
            end
            if (GRPBITS'(g) == r_cur) begin
                w_cur_slice = r_mask[g*MULLANES +: MULLANES];
            end
        end
    end

    assign w_grp_valid = (r_state == S_RUN) && bus.en;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_mask  <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_pv    <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_ps[i] <= '0;
            end
        end else if (bus.squash) begin
            r_state <= S_IDLE;
            r_pv    <= '0;
        end else if (bus.en) begin
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
            end
            r_pv[0] <= w_grp_valid;
            r_ps[0] <= r_cur;

            case (r_state)
                S_IDLE: begin
                    if (bus.issue_valid) begin
                        r_mask <= bus.issue_mask;
                        r_op   <= bus.issue_op;
                        if (w_first_found) begin
                            r_state <= S_RUN;
                            r_cur   <= w_first_grp;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_next_found) begin
                        r_cur <= w_next_grp;
                    end else begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CNTW'(LAT - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.issue_ready = (r_state == S_IDLE);
    assign bus.grp_valid   = w_grp_valid;
    assign bus.grp_sel     = r_cur;
    assign bus.grp_mask    = w_cur_slice;
    assign bus.grp_op      = r_op;
    assign bus.cap_valid   = r_pv[LAT-1] & bus.en;
    assign bus.cap_sel     = r_ps[LAT-1];
    assign bus.stall       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done        = (r_state == S_FIN) && bus.en;

endmodule

`default_nettype wire

// File: tb/tb_vmul_group_sched.sv
// +------------------------------------------------------------------+
// | tb_vmul_group_sched                                              |
// | Directed self-checking bench for vmul_group_sched (defaults).    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_vmul_group_sched;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    logic       e_gv, e_cv, e_st, e_dn, e_rd;
    logic [0:0] e_gs, e_cs;
    logic [3:0] e_gm;
    logic [4:0] e_go;

    vmul_group_sched_if #(.NUMLANES(8), .MULLANES(4), .GRPBITS(1)) vif ();

    vmul_group_sched #(.NUMLANES(8), .MULLANES(4), .GRPBITS(1), .LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({vif.issue_ready, vif.grp_valid, vif.cap_valid, vif.stall, vif.done,
             vif.grp_sel, vif.cap_sel, vif.grp_mask, vif.grp_op} !== {5'b10000, 2'b00, 4'h0, 5'h00}) begin
            n_errors++;
            $display("FAIL reset_values got rdy=%b gv=%b cv=%b st=%b dn=%b gs=%h cs=%h gm=%h go=%h exp rdy=1 rest 0",
                     vif.issue_ready, vif.grp_valid, vif.cap_valid, vif.stall, vif.done,
                     vif.grp_sel, vif.cap_sel, vif.grp_mask, vif.grp_op);
        end
        next_cycle();
        resetn = 1'b1;
    endtask

    task automatic test_full_mask();
        for (int c = 0; c <= 6; c++) begin
            vif.issue_valid = (c == 0);
            vif.issue_mask  = 8'hFF;
            vif.issue_op    = 5'h03;
            @(negedge clk);
            e_gv = (c == 1) || (c == 2);  e_gs = 1'(c - 1);
            e_cv = (c == 3) || (c == 4);  e_cs = 1'(c - 3);
            e_st = (c >= 1) && (c <= 4);  e_dn = (c == 5);
            e_rd = (c == 0) || (c == 6);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {e_gv, e_cv, e_st, e_dn, e_rd}) begin
                n_errors++;
                $display("FAIL full_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp %b%b%b%b%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_gv, e_cv, e_st, e_dn, e_rd);
            end
            if (e_gv) begin
                n_checks++;
                if ({vif.grp_sel, vif.grp_mask, vif.grp_op} !== {e_gs, 4'hF, 5'h03}) begin
                    n_errors++;
                    $display("FAIL full_grp c=%0d got sel=%h mask=%h op=%h exp sel=%h mask=f op=03", c,
                             vif.grp_sel, vif.grp_mask, vif.grp_op, e_gs);
                end
            end
            if (e_cv) begin
                n_checks++;
                if (vif.cap_sel !== e_cs) begin
                    n_errors++;
                    $display("FAIL full_cap c=%0d got cap_sel=%h exp %h", c, vif.cap_sel, e_cs);
                end
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
    endtask

    task automatic test_upper_mask();
        for (int c = 0; c <= 5; c++) begin
            vif.issue_valid = (c == 0);
            vif.issue_mask  = 8'hF0;
            vif.issue_op    = 5'h0A;
            @(negedge clk);
            e_gv = (c == 1);  e_cv = (c == 3);
            e_st = (c >= 1) && (c <= 3);  e_dn = (c == 4);
            e_rd = (c == 0) || (c == 5);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {e_gv, e_cv, e_st, e_dn, e_rd}) begin
                n_errors++;
                $display("FAIL upper_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp %b%b%b%b%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_gv, e_cv, e_st, e_dn, e_rd);
            end
            if (e_gv) begin
                n_checks++;
                if ({vif.grp_sel, vif.grp_mask, vif.grp_op} !== {1'b1, 4'hF, 5'h0A}) begin
                    n_errors++;
                    $display("FAIL upper_grp c=%0d got sel=%h mask=%h op=%h exp sel=1 mask=f op=0a", c,
                             vif.grp_sel, vif.grp_mask, vif.grp_op);
                end
            end
            if (e_cv) begin
                n_checks++;
                if (vif.cap_sel !== 1'b1) begin
                    n_errors++;
                    $display("FAIL upper_cap c=%0d got cap_sel=%h exp 1", c, vif.cap_sel);
                end
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
    endtask

    task automatic test_zero_mask();
        for (int c = 0; c <= 2; c++) begin
            vif.issue_valid = (c == 0);
            vif.issue_mask  = 8'h00;
            vif.issue_op    = 5'h11;
            @(negedge clk);
            e_dn = (c == 1);
            e_rd = (c != 1);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {3'b000, e_dn, e_rd}) begin
                n_errors++;
                $display("FAIL zero_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp 000%b%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_dn, e_rd);
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
    endtask

    task automatic test_en_stall();
        for (int c = 0; c <= 7; c++) begin
            vif.issue_valid = (c == 0);
            vif.issue_mask  = 8'hFF;
            vif.issue_op    = 5'h07;
            vif.en          = (c != 2);
            @(negedge clk);
            e_gv = (c == 1) || (c == 3);  e_gs = (c == 1) ? 1'b0 : 1'b1;
            e_cv = (c == 4) || (c == 5);  e_cs = 1'(c - 4);
            e_st = (c >= 1) && (c <= 5);  e_dn = (c == 6);
            e_rd = (c == 0) || (c == 7);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {e_gv, e_cv, e_st, e_dn, e_rd}) begin
                n_errors++;
                $display("FAIL en_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp %b%b%b%b%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_gv, e_cv, e_st, e_dn, e_rd);
            end
            if (e_gv || (c == 2)) begin
                n_checks++;
                if ({vif.grp_sel, vif.grp_op} !== {e_gs, 5'h07}) begin
                    n_errors++;
                    $display("FAIL en_grp c=%0d got sel=%h op=%h exp sel=%h op=07", c, vif.grp_sel, vif.grp_op, e_gs);
                end
            end
            if (e_cv) begin
                n_checks++;
                if (vif.cap_sel !== e_cs) begin
                    n_errors++;
                    $display("FAIL en_cap c=%0d got cap_sel=%h exp %h", c, vif.cap_sel, e_cs);
                end
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
        vif.en          = 1'b1;
    endtask

    task automatic test_squash();
        for (int c = 0; c <= 8; c++) begin
            vif.issue_valid = (c == 0) || (c == 3);
            vif.issue_mask  = (c == 3) ? 8'h0F : 8'hFF;
            vif.issue_op    = (c == 3) ? 5'h09 : 5'h03;
            vif.squash      = (c == 2);
            @(negedge clk);
            e_gv = (c == 1) || (c == 2) || (c == 4);
            e_gs = (c == 2) ? 1'b1 : 1'b0;
            e_go = (c == 4) ? 5'h09 : 5'h03;
            e_cv = (c == 6);
            e_st = (c == 1) || (c == 2) || ((c >= 4) && (c <= 6));
            e_dn = (c == 7);
            e_rd = (c == 0) || (c == 3) || (c == 8);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {e_gv, e_cv, e_st, e_dn, e_rd}) begin
                n_errors++;
                $display("FAIL squash_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp %b%b%b%b%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_gv, e_cv, e_st, e_dn, e_rd);
            end
            if (e_gv) begin
                n_checks++;
                if ({vif.grp_sel, vif.grp_mask, vif.grp_op} !== {e_gs, 4'hF, e_go}) begin
                    n_errors++;
                    $display("FAIL squash_grp c=%0d got sel=%h mask=%h op=%h exp sel=%h mask=f op=%h", c,
                             vif.grp_sel, vif.grp_mask, vif.grp_op, e_gs, e_go);
                end
            end
            if (e_cv) begin
                n_checks++;
                if (vif.cap_sel !== 1'b0) begin
                    n_errors++;
                    $display("FAIL squash_cap c=%0d got cap_sel=%h exp 0", c, vif.cap_sel);
                end
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
        vif.squash      = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 7; c++) begin
            vif.issue_valid = (c == 0);
            vif.issue_mask  = 8'hFF;
            vif.issue_op    = 5'h03;
            resetn          = (c != 3);
            @(negedge clk);
            e_gv = (c == 1) || (c == 2);
            e_cv = (c == 3);
            e_st = (c >= 1) && (c <= 3);
            e_rd = (c == 0) || (c >= 4);
            n_checks++;
            if ({vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready} !== {e_gv, e_cv, e_st, 1'b0, e_rd}) begin
                n_errors++;
                $display("FAIL rstmid_ctl c=%0d got gv/cv/st/dn/rdy=%b%b%b%b%b exp %b%b%b0%b", c,
                         vif.grp_valid, vif.cap_valid, vif.stall, vif.done, vif.issue_ready, e_gv, e_cv, e_st, e_rd);
            end
            if (c == 4) begin
                n_checks++;
                if ({vif.grp_sel, vif.cap_sel, vif.grp_mask, vif.grp_op} !== {2'b00, 4'h0, 5'h00}) begin
                    n_errors++;
                    $display("FAIL rstmid_regs c=%0d got gs=%h cs=%h gm=%h go=%h exp all 0", c,
                             vif.grp_sel, vif.cap_sel, vif.grp_mask, vif.grp_op);
                end
            end
            next_cycle();
        end
        vif.issue_valid = 1'b0;
        resetn          = 1'b1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        resetn          = 1'b0;
        vif.en          = 1'b1;
        vif.squash      = 1'b0;
        vif.issue_valid = 1'b0;
        vif.issue_mask  = 8'h00;
        vif.issue_op    = 5'h00;
        test_reset();
        test_full_mask();
        test_upper_mask();
        test_zero_mask();
        test_en_stall();
        test_squash();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/vmul_group_sched.md
# vmul_group_sched

Issue-side scheduler for the vector multiply unit when the vector has more lanes than physical multipliers. It accepts one vector multiply, walks its lanes in groups of MULLANES, skips groups whose mask bits are all zero, and drives the shared multiplier bank one group per enabled cycle. It tags each result returning from the fixed-latency multiplier with its group index so a downstream collector can write the result into the correct lane slice. It sits between the lane issue logic (stall/en pipeline) and the multiplier/result buffers.

## Interface
- NUMLANES, 8: vector lanes; a multiple of MULLANES.
- MULLANES, 4: physical multipliers, i.e. lanes per group.
- NUMGRP, NUMLANES/MULLANES: number of groups.
- GRPBITS, 1: width of group index; ≥ 1 and 2**GRPBITS ≥ NUMGRP.
- LAT, 2: multiplier latency in enabled cycles; range 1..3.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- en  in  1  pipeline enable; when 0, all state freezes.
- squash  in  1  abort current operation.
- issue_valid  in  1  new multiply presented.
- issue_ready  out  1  scheduler idle; the operation is accepted when both issue_valid and issue_ready are high and en=1.
- issue_mask  in  NUMLANES  lane mask.
- issue_op  in  5  multiply opcode.
- grp_valid  out  1  a group is driven to the multipliers this cycle.
- grp_sel  out  GRPBITS  index of the driven group.
- grp_mask  out  MULLANES  issue_mask[grp_sel*MULLANES +: MULLANES].
- grp_op  out  5  latched opcode.
- cap_valid  out  1  result of a group is available this cycle.
- cap_sel  out  GRPBITS  group index of that result.
- stall  out  1  hold the upstream pipeline.
- done  out  1  single-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, FIN. Reset state is IDLE.
- State transitions occur only in cycles with en=1. The one exception is reset.
- IDLE
  - issue_ready=1.
  - On accept, latch mask and op.
  - If the mask is nonzero, go to RUN with cur = lowest group that has a nonzero mask slice.
  - If the mask is all zero, go to FIN.
- RUN
  - grp_valid = en.
  - grp_sel = cur; grp_mask = slice of cur; grp_op = latched op.
  - On en, advance cur to the next higher group with a nonzero slice.
  - If no such group remains, go to DRAIN and load the drain counter with LAT-1.
- DRAIN
  - No grp_valid.
  - Decrement the counter on each en cycle.
  - Go to FIN when the counter is 0 and en=1.
- FIN
  - done = en.
  - Go to IDLE on en.
- Capture pipe
  - LAT-deep shift register of {valid, sel}.
  - Shift in {grp_valid, grp_sel} on each en cycle.
  - cap_valid = tail.valid & en; cap_sel = tail.sel.
- stall = (state==RUN) | (state==DRAIN).
  - It is not asserted in IDLE or FIN, nor for an all-zero mask.
- squash (takes priority over en and over accept)
  - Next state is IDLE.
  - All capture-pipe valid bits are cleared.
  - No done pulse is produced; latched mask/op are don't-care.
  - An issue presented in the same cycle as squash is not accepted.
- Groups are always issued in ascending index order. Skipped groups produce no grp_valid and no cap_valid.

## Timing
- Reset values:
  - issue_ready=1; grp_valid=0; cap_valid=0; stall=0; done=0.
  - grp_sel=0; cap_sel=0; grp_mask=0; grp_op=0.
  - Capture pipe cleared.
- Reset mid-operation aborts the operation exactly as squash does and additionally clears the latched registers.
- With all en=1 and accept at cycle t, and k nonzero groups (k ≥ 1):
  - grp_valid in cycles t+1 .. t+k.
  - cap_valid in cycles t+1+LAT .. t+k+LAT.
  - done in cycle t+k+LAT+1.
  - stall in cycles t+1 .. t+k+LAT.
- With k=0: done in cycle t+1, and no stall, grp_valid or cap_valid.
- Each en=0 cycle delays every later event by exactly one cycle. Outputs qualified by en (grp_valid, cap_valid, done) read 0 during that cycle.
- No back-to-back issue: the earliest next accept is the cycle after done (IDLE).

## Test plan
Unless stated, parameters are defaults (NUMLANES=8, MULLANES=4, LAT=2), en=1 and accept is at cycle 0.
- issue_mask=0xFF, op=5'h3 -> grp_valid at cycles 1,2 with sel 0,1, grp_mask 0xF, grp_op 3; cap_valid at cycles 3,4 with sel 0,1; done at cycle 5; stall at cycles 1-4.
- issue_mask=0xF0 -> grp_valid only at cycle 1 with sel=1, mask 0xF; cap_valid at cycle 3 with sel=1; done at cycle 4; stall at cycles 1-3.
- issue_mask=0x00 -> done at cycle 1; grp_valid, cap_valid and stall stay 0; issue_ready=1 at cycle 2.
- mask 0xFF with en=0 at cycle 2 -> grp_valid at cycles 1,3; cap_valid at cycles 4,5; done at cycle 6; grp_valid=0 and sel held at 1 during cycle 2.
- mask 0xFF with squash at cycle 2 -> IDLE at cycle 3 (issue_ready=1, stall=0); no cap_valid and no done afterward. A new issue with mask 0x0F at cycle 3 yields grp_valid sel=0 at cycle 4 and done at cycle 7.
- resetn=0 at cycle 3 of the mask 0xFF case -> cycle 4 shows all reset values; no done ever.
